// File: rtl/npu_pkg.sv
// Shared NPU datapath constants: popcount width/range and a constant-evaluable clog2.
package npu_pkg;

   localparam int POP_W   = 4;
   localparam int POP_MAX = 13;

   typedef enum logic {
      ACCUM = 1'b0,
      FULL  = 1'b1
   } acc_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/popcnt_accumulator_sat_adder.sv
// Saturating adder: ACC_W-bit accumulator plus a POP_W-bit popcount, clamped to all-ones.
module sat_adder
   import npu_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [POP_W-1:0] add_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             clamp_o
);

   logic [ACC_W:0] wide_sum;

   always_comb begin
      wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - POP_W){1'b0}}, add_i};
      clamp_o  = wide_sum[ACC_W];
      sum_o    = clamp_o ? '1 : wide_sum[ACC_W-1:0];
   end

endmodule

// File: rtl/popcnt_accumulator.sv
// Accumulates per-beat popcounts of one pixel into a saturating sum and hands it out over valid/ready.
// Optional binarised activation output is enabled with `define POPACC_THRESH_EN.
module popcnt_accumulator
   import npu_pkg::*;
#(
   parameter int ACC_W     = 16,
   parameter int MAX_BEATS = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [POP_W-1:0] in_cnt,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_sat,
   output logic             out_trunc
`ifdef POPACC_THRESH_EN
   ,
   input  logic [ACC_W-1:0] thresh,
   output logic             out_act
`endif
);

   localparam int              CNT_W    = clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sticky_q, sticky_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic             sat_q, sat_d;
   logic             trunc_q, trunc_d;
`ifdef POPACC_THRESH_EN
   logic             act_q, act_d;
`endif

   logic [ACC_W-1:0] add_sum;
   logic             add_clamp;
   logic             beat_fire;
   logic             out_fire;
   logic             beat_is_last;

   sat_adder #(
      .ACC_W (ACC_W)
   ) u_sat_adder (
      .acc_i   (acc_q),
      .add_i   (in_cnt),
      .sum_o   (add_sum),
      .clamp_o (add_clamp)
   );

   // A pending result blocks new beats unless it is being drained this same cycle.
   assign out_valid    = (state_q == FULL);
   assign in_ready     = !out_valid || out_ready;
   assign beat_fire    = in_valid && in_ready;
   assign out_fire     = out_valid && out_ready;
   assign beat_is_last = in_last || (cnt_q == LAST_CNT);

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         ACCUM: if (beat_fire && beat_is_last) state_d = FULL;
         FULL:  if (out_fire && !(beat_fire && beat_is_last)) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      sum_d    = sum_q;
      sat_d    = sat_q;
      trunc_d  = trunc_q;
`ifdef POPACC_THRESH_EN
      act_d    = act_q;
`endif
      if (beat_fire) begin
         if (beat_is_last) begin
            sum_d    = add_sum;
            sat_d    = sticky_q | add_clamp;
            trunc_d  = !in_last;
`ifdef POPACC_THRESH_EN
            act_d    = (add_sum >= thresh);
`endif
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
         end else begin
            acc_d    = add_sum;
            cnt_d    = cnt_q + CNT_W'(1);
            sticky_d = sticky_q | add_clamp;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
      if (rst) begin
         state_q  <= ACCUM;
         acc_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         sum_q    <= '0;
         sat_q    <= 1'b0;
         trunc_q  <= 1'b0;
`ifdef POPACC_THRESH_EN
         act_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         sum_q    <= sum_d;
         sat_q    <= sat_d;
         trunc_q  <= trunc_d;
`ifdef POPACC_THRESH_EN
         act_q    <= act_d;
`endif
      end
   end

   assign out_sum   = sum_q;
   assign out_sat   = sat_q;
   assign out_trunc = trunc_q;
`ifdef POPACC_THRESH_EN
   assign out_act   = act_q;
`endif

`ifndef SYNTHESIS
   // The compression adder never produces more than 13; larger values point to an upstream fault.
   cnt_range_a: assert property (@(posedge clk) disable iff (rst)
      (in_valid && in_ready) |-> (in_cnt <= POP_W'(POP_MAX)));
`endif

endmodule

// File: tb/tb_popcnt_accumulator.sv
// Bench: a default instance and a narrow instance (ACC_W=5, MAX_BEATS=4) checked against a pixel-level model.
module tb_popcnt_accumulator;

   localparam int N_INST = 2;
   localparam int THR    = 20;

   logic clk = 1'b0;
   logic rst;

   logic       in_valid  [N_INST];
   logic       in_ready  [N_INST];
   logic [3:0] in_cnt    [N_INST];
   logic       in_last   [N_INST];
   logic       out_valid [N_INST];
   logic       out_ready [N_INST];
   logic       out_sat   [N_INST];
   logic       out_trunc [N_INST];
   logic [15:0] out_sum0;
   logic [4:0]  out_sum1;
`ifdef POPACC_THRESH_EN
   logic        out_act  [N_INST];
   logic [15:0] thresh0 = 16'(THR);
   logic [4:0]  thresh1 = 5'(THR);
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a pixel is the running total of its beats; the result is min(total, max).
   int max_val   [N_INST] = '{65535, 31};
   int max_beats [N_INST] = '{64, 4};
   int m_total   [N_INST];
   int m_count   [N_INST];
   int m_sum     [N_INST];
   bit m_ov      [N_INST];
   bit m_sat     [N_INST];
   bit m_trunc   [N_INST];
   bit m_act     [N_INST];
   bit m_fresh   [N_INST];

   always #5 clk = ~clk;

   popcnt_accumulator #(.ACC_W(16), .MAX_BEATS(64)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_cnt    (in_cnt[0]),
      .in_last   (in_last[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_sum   (out_sum0),
      .out_sat   (out_sat[0]),
      .out_trunc (out_trunc[0])
`ifdef POPACC_THRESH_EN
      ,
      .thresh    (thresh0),
      .out_act   (out_act[0])
`endif
   );

   popcnt_accumulator #(.ACC_W(5), .MAX_BEATS(4)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_cnt    (in_cnt[1]),
      .in_last   (in_last[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_sum   (out_sum1),
      .out_sat   (out_sat[1]),
      .out_trunc (out_trunc[1])
`ifdef POPACC_THRESH_EN
      ,
      .thresh    (thresh1),
      .out_act   (out_act[1])
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      n_tests++;
      if (got !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sum_of(input int i);
      return (i == 0) ? 32'(out_sum0) : 32'(out_sum1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_INST; i++) begin
         m_total[i] = 0; m_count[i] = 0; m_sum[i] = 0;
         m_ov[i] = 0; m_sat[i] = 0; m_trunc[i] = 0; m_act[i] = 0; m_fresh[i] = 1;
      end
   endtask

   task automatic idle(input int i);
      in_valid[i] = 1'b0; in_cnt[i] = 4'd0; in_last[i] = 1'b0; out_ready[i] = 1'b1;
   endtask

   task automatic drive(input int i, input bit v, input int c, input bit l, input bit r);
      in_valid[i] = v; in_cnt[i] = 4'(c); in_last[i] = l; out_ready[i] = r;
   endtask

   // Called just after a falling edge with inputs set; checks in_ready, advances the model
   // across the next rising edge and compares outputs at the following falling edge.
   task automatic step();
      bit rdy;
      #1;
      for (int i = 0; i < N_INST; i++) begin
         rdy = !m_ov[i] || out_ready[i];
         check($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), int'(rdy));
         if (rst) begin
            m_total[i] = 0; m_count[i] = 0; m_sum[i] = 0;
            m_ov[i] = 0; m_sat[i] = 0; m_trunc[i] = 0; m_act[i] = 0; m_fresh[i] = 1;
         end else begin
            if (m_ov[i] && out_ready[i]) m_ov[i] = 0;
            if (in_valid[i] && rdy) begin
               m_total[i] += int'(in_cnt[i]);
               m_count[i]++;
               if (in_last[i] || m_count[i] == max_beats[i]) begin
                  m_ov[i]    = 1;
                  m_sum[i]   = (m_total[i] > max_val[i]) ? max_val[i] : m_total[i];
                  m_sat[i]   = (m_total[i] > max_val[i]);
                  m_trunc[i] = !in_last[i];
                  m_act[i]   = (m_sum[i] >= THR);
                  m_fresh[i] = 0;
                  m_total[i] = 0;
                  m_count[i] = 0;
               end
            end
         end
      end
      @(negedge clk);
      for (int i = 0; i < N_INST; i++) begin
         check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), int'(m_ov[i]));
         if (m_ov[i] || m_fresh[i]) begin
            check($sformatf("out_sum[%0d]", i), sum_of(i), m_sum[i]);
            check($sformatf("out_sat[%0d]", i), 32'(out_sat[i]), int'(m_sat[i]));
            check($sformatf("out_trunc[%0d]", i), 32'(out_trunc[i]), int'(m_trunc[i]));
`ifdef POPACC_THRESH_EN
            check($sformatf("out_act[%0d]", i), 32'(out_act[i]), int'(m_act[i]));
`endif
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle(0); idle(1);
      model_reset();
      @(negedge clk);
      step(); step();
      check("reset_sum0", sum_of(0), 0);
      check("reset_valid1", 32'(out_valid[1]), 0);
      rst = 1'b0;

      // 13,13,5 -> 31 one cycle after the last beat
      drive(0, 1, 13, 0, 1); step();
      drive(0, 1, 13, 0, 1); step();
      check("t1_not_yet", 32'(out_valid[0]), 0);
      drive(0, 1, 5, 1, 1); step();
      check("t1_sum", sum_of(0), 31);
      check("t1_valid", 32'(out_valid[0]), 1);
      idle(0); step();

      // back-to-back single-beat pixels
      drive(0, 1, 3, 1, 1); step();
      check("t2_sum_a", sum_of(0), 3);
      drive(0, 1, 7, 1, 1); step();
      check("t2_sum_b", sum_of(0), 7);
      drive(0, 1, 0, 1, 1); step();
      check("t2_sum_c", sum_of(0), 0);
      check("t2_valid_c", 32'(out_valid[0]), 1);
      idle(0); step();

      // backpressure: result held, next beat waits, accepted on release
      drive(0, 1, 6, 1, 1); step();
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 9, 1, 0); step();
         check("t3_hold_sum", sum_of(0), 6);
      end
      drive(0, 1, 9, 1, 1); step();
      check("t3_release_sum", sum_of(0), 9);
      idle(0); step();

      // saturation on the narrow instance, then a clean pixel
      drive(1, 1, 13, 0, 1); step();
      drive(1, 1, 13, 0, 1); step();
      drive(1, 1, 13, 1, 1); step();
      check("t4_sum", sum_of(1), 31);
      check("t4_sat", 32'(out_sat[1]), 1);
      drive(1, 1, 2, 1, 1); step();
      check("t4_next_sum", sum_of(1), 2);
      check("t4_next_sat", 32'(out_sat[1]), 0);
      idle(1); step();

      // MAX_BEATS closes a pixel, the 5th beat starts a new one
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 1, 0, 1); step();
      end
      check("t5_sum", sum_of(1), 4);
      check("t5_trunc", 32'(out_trunc[1]), 1);
      drive(1, 1, 1, 0, 1); step();
      check("t5_new_pixel_idle", 32'(out_valid[1]), 0);
      drive(1, 1, 1, 1, 1); step();
      check("t5_new_sum", sum_of(1), 2);
      check("t5_new_trunc", 32'(out_trunc[1]), 0);
      idle(1); step();

      // reset mid-pixel discards the partial sum
      drive(0, 1, 9, 0, 1); step();
      drive(0, 1, 9, 0, 1); step();
      idle(0); rst = 1'b1; step();
      check("t6_rst_sum", sum_of(0), 0);
      check("t6_rst_valid", 32'(out_valid[0]), 0);
      rst = 1'b0;
      drive(0, 1, 4, 1, 1); step();
      check("t6_sum", sum_of(0), 4);
      idle(0); step();

`ifdef POPACC_THRESH_EN
      drive(0, 1, 13, 0, 1); step();
      drive(0, 1, 13, 1, 1); step();
      check("t7_act", 32'(out_act[0]), 1);
      idle(0); step();
`endif

      // randomized traffic on both instances
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < N_INST; i++) begin
            drive(i, ($urandom_range(0, 9) < 7), $urandom_range(0, 13),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
         end
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
